// File: rtl/add_bist_pkg.sv
// Shared types and the golden-sum helper for the adder self-test engine.
package add_bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } state_e;

  // Widest adder the helper can model; callers truncate to WIDTH+1 bits.
  localparam int MAX_W = 32;

  function automatic logic [MAX_W:0] expected_sum(input logic [MAX_W-1:0] a,
                                                  input logic [MAX_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/add_bist.sv
// Exhaustive self-test driver/checker for a combinational WIDTH-bit adder.
// Sweeps every operand pair, counts mismatches and records the first one.
module add_bist
  import add_bist_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  input  logic [WIDTH-1:0] dut_s,
  input  logic             dut_cout
);

  localparam int IW = 2 * WIDTH;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               fv_q, fv_d;
  logic [WIDTH-1:0]   fa_q, fa_d;
  logic [WIDTH-1:0]   fb_q, fb_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               pass_q, pass_d;

  logic [WIDTH:0]     exp_sum;
  logic               mismatch;
  logic               last_vec;
  logic               settle_end;

  assign exp_sum    = (WIDTH+1)'(expected_sum(MAX_W'(a_q), MAX_W'(b_q)));
  assign mismatch   = ({dut_cout, dut_s} != exp_sum);
  assign last_vec   = &idx_q;
  assign settle_end = (cnt_q == CW'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fa_q    <= '0;
      fb_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETTLE;
      SETTLE:  if (settle_end) state_d = CHECK;
      CHECK:   state_d = last_vec ? DONE : SETTLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SETTLE) || (state_q == CHECK);
    done = (state_q == DONE);
  end

  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    fv_d   = fv_q;
    fa_d   = fa_q;
    fb_d   = fb_q;
    a_d    = a_q;
    b_d    = b_q;
    pass_d = pass_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d  = '0;
          a_d    = '0;
          b_d    = '0;
          err_d  = '0;
          fv_d   = 1'b0;
          pass_d = 1'b0;
          cnt_d  = '0;
        end
      end
      SETTLE: cnt_d = cnt_q + 1'b1;
      CHECK: begin
        if (mismatch) begin
          if (!(&err_q)) err_d = err_q + 1'b1;
          if (!fv_q) begin
            fa_d = a_q;
            fb_d = b_q;
            fv_d = 1'b1;
          end
        end
        // pass is settled here so it is already valid alongside the done pulse
        if (last_vec) begin
          pass_d = (err_d == '0);
        end else begin
          idx_d = idx_q + 1'b1;
          a_d   = idx_d[WIDTH-1:0];
          b_d   = idx_d[IW-1:WIDTH];
          cnt_d = '0;
        end
      end
      DONE: begin
        a_d = '0;
        b_d = '0;
      end
      default: ;
    endcase
  end

  assign pass            = pass_q;
  assign err_cnt         = err_q;
  assign first_err_valid = fv_q;
  assign first_err_a     = fa_q;
  assign first_err_b     = fb_q;
  assign dut_a           = a_q;
  assign dut_b           = b_q;

endmodule

// File: tb/tb_add_bist.sv
// Scoreboarded random bench: three BIST configurations driven against faulty adder models.
module tb_add_bist;

  localparam int W = 4;
  localparam int N = 3;
  localparam int SET_P  [N] = '{1, 1, 3};
  localparam int ERRW_P [N] = '{9, 4, 9};

  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscmp  = 0;
  int st_cyc  = 0;
  int pend [N];
  int mode [N];
  logic [W-1:0] tgt_a [N];
  logic [W-1:0] tgt_b [N];
  logic [W:0]   msk   [N];

  event sweep_ev, flush_ev, rst_chk_ev;

  task automatic check(input string nm, input int g, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscmp++;
      $display("FAIL %s inst%0d actual=%0d required=%0d (cycle %0d)", nm, g, act, req, cyc);
    end
  endtask

  // Adder under test: correct sum with an optional planted fault.
  function automatic logic [W:0] adder_model(input int m, input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] ta, input logic [W-1:0] tb,
                                             input logic [W:0] mk);
    logic [W:0] r;
    r = {1'b0, a} + {1'b0, b};
    case (m)
      1: r[W] = 1'b0;
      2: r[0] = 1'b1;
      3: if (a == ta && b == tb) r = r ^ mk;
      default: ;
    endcase
    return r;
  endfunction

  for (genvar gi = 0; gi < N; gi++) begin : g
    localparam int S  = SET_P[gi];
    localparam int EW = ERRW_P[gi];

    logic          busy, done, pass, fv, dc;
    logic [EW-1:0] err_cnt;
    logic [W-1:0]  fa, fb, da, db, ds;

    assign {dc, ds} = adder_model(mode[gi], da, db, tgt_a[gi], tgt_b[gi], msk[gi]);

    add_bist #(.WIDTH(W), .SETTLE_CYCLES(S), .ERR_W(EW)) dut (
      .clk(clk), .rst(rst), .start(start),
      .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
      .first_err_valid(fv), .first_err_a(fa), .first_err_b(fb),
      .dut_a(da), .dut_b(db), .dut_s(ds), .dut_cout(dc)
    );

    typedef struct {
      int done_rel;
      int errs;
      bit pass;
      bit fv;
      int fa;
      int fb;
    } exp_t;
    exp_t q[$];
    int   rel;

    // Reference: walk all pairs in sweep order, count wrong sums, saturate.
    initial forever begin
      exp_t e;
      int raw;
      @(sweep_ev);
      raw = 0;
      e.fv = 0; e.fa = 0; e.fb = 0;
      for (int k = 0; k < (1 << (2 * W)); k++) begin
        int a, b;
        a = k % (1 << W);
        b = k / (1 << W);
        if (adder_model(mode[gi], W'(a), W'(b), tgt_a[gi], tgt_b[gi], msk[gi]) != (W+1)'(a + b)) begin
          raw++;
          if (!e.fv) begin e.fv = 1; e.fa = a; e.fb = b; end
        end
      end
      e.errs     = (raw > (1 << EW) - 1) ? (1 << EW) - 1 : raw;
      e.pass     = (raw == 0);
      e.done_rel = (1 << (2 * W)) * (S + 1) + 1;
      q.push_back(e);
      pend[gi]++;
    end

    initial forever begin
      @(flush_ev);
      q.delete();
      pend[gi] = 0;
    end

    initial forever begin
      @(rst_chk_ev);
      check("rst_busy", gi, busy, 0);
      check("rst_done", gi, done, 0);
      check("rst_pass", gi, pass, 0);
      check("rst_fv",   gi, fv, 0);
      check("rst_err",  gi, err_cnt, 0);
      check("rst_fa",   gi, fa, 0);
      check("rst_fb",   gi, fb, 0);
      check("rst_da",   gi, da, 0);
      check("rst_db",   gi, db, 0);
    end

    always @(negedge clk) begin
      if (!rst) begin
        rel = cyc - st_cyc;
        if (q.size() > 0 && rel >= 1 && rel < q[0].done_rel) begin
          check("busy", gi, busy, 1);
          check("early_done", gi, done, 0);
          check("dut_a", gi, da, ((rel - 1) / (S + 1)) % (1 << W));
          check("dut_b", gi, db, ((rel - 1) / (S + 1)) / (1 << W));
        end else if (q.size() > 0 && rel == q[0].done_rel) begin
          exp_t e;
          e = q.pop_front();
          pend[gi]--;
          check("done", gi, done, 1);
          check("busy_at_done", gi, busy, 0);
          check("err_cnt", gi, err_cnt, e.errs);
          check("pass", gi, pass, e.pass);
          check("first_err_valid", gi, fv, e.fv);
          if (e.fv) begin
            check("first_err_a", gi, fa, e.fa);
            check("first_err_b", gi, fb, e.fb);
          end
          $display("sweep inst%0d mode=%0d err_cnt=%0d/%0d pass=%0b first=(%0d,%0d) done_rel=%0d",
                   gi, mode[gi], err_cnt, e.errs, pass, fa, fb, rel);
        end else if (done) begin
          check("spurious_done", gi, done, 0);
        end
      end
    end
  end

  task automatic wait_rel(input int r);
    while (cyc - st_cyc < r) @(negedge clk);
  endtask

  task automatic issue_start();
    @(negedge clk);
    st_cyc = cyc;
    start  = 1'b1;
    ->sweep_ev;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_start_at(input int r);
    wait_rel(r);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_sweep(input bit repulse, input bit do_rst);
    int tmo;
    issue_start();
    if (do_rst) begin
      wait_rel($urandom_range(50, 400));
      rst = 1'b1;
      ->flush_ev;
      @(negedge clk);
      ->rst_chk_ev;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      issue_start();
    end else if (repulse) begin
      pulse_start_at(10);
      pulse_start_at(300);
    end
    tmo = 0;
    while ((pend[0] + pend[1] + pend[2]) != 0 && tmo < 3000) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 3000) begin
      vectors++;
      miscmp++;
      $display("FAIL sweep_timeout actual=pending required=0 (cycle %0d)", cyc);
      ->flush_ev;
    end
    // start during the DONE cycle is ignored, so leave a gap before the next sweep
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      mode[i] = 0; tgt_a[i] = '0; tgt_b[i] = '0; msk[i] = 1; pend[i] = 0;
    end
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    ->rst_chk_ev;
    #1;
    rst = 1'b0;

    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < N; i++) begin
        case (s)
          0: mode[i] = 0;
          1: mode[i] = (i == 0) ? 1 : (i == 1) ? 2 : 0;
          2: mode[i] = (i == 2) ? 3 : 2;
          default: mode[i] = $urandom_range(0, 3);
        endcase
        tgt_a[i] = W'($urandom_range(0, 15));
        tgt_b[i] = W'($urandom_range(0, 15));
        msk[i]   = (W+1)'($urandom_range(1, 31));
      end
      run_sweep((s == 3) || (s > 4 && $urandom_range(0, 1) == 1), s == 4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
    $finish;
  end

endmodule
